// File: rtl/iq_integrate_dump.sv
// Integrate-and-dump over streamed I/Q samples with scaled, saturated per-frame output.
// Optional round-half-up before the shift when IQ_INTDUMP_ROUND_EN is defined.
module iq_integrate_dump #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int SHIFT      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LEN_WIDTH-1:0]    len,
    input  logic                    in_tvalid,
    output logic                    in_tready,
    input  logic [2*DATA_WIDTH-1:0] in_tdata,
    input  logic                    in_tlast,
    output logic                    out_tvalid,
    input  logic                    out_tready,
    output logic [2*OUT_WIDTH-1:0]  out_tdata,
    output logic                    out_tlast,
    output logic                    out_sat
);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

`ifdef IQ_INTDUMP_ROUND_EN
    localparam logic signed [ACC_WIDTH-1:0] ROUND_BIAS = ACC_WIDTH'((2 ** SHIFT) / 2);
`else
    localparam logic signed [ACC_WIDTH-1:0] ROUND_BIAS = '0;
`endif

    logic [0:0]                  state;
    logic signed [ACC_WIDTH-1:0] acc_i, acc_q;
    logic signed [ACC_WIDTH-1:0] beat_i, beat_q;
    logic signed [ACC_WIDTH-1:0] total_i, total_q;
    logic signed [ACC_WIDTH-1:0] scaled_i, scaled_q;
    logic [LEN_WIDTH-1:0]        cnt, len_q, frame_len;
    logic [OUT_WIDTH-1:0]        sat_i, sat_q;
    logic                        clip_i, clip_q;
    logic                        accept, dump;

    // Returns {clipped, value} with the value clamped to the signed output range.
    function automatic logic [OUT_WIDTH:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
        if (v > SAT_MAX)
            return {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
        else if (v < SAT_MIN)
            return {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
        else
            return {1'b0, v[OUT_WIDTH-1:0]};
    endfunction

    assign out_tvalid = (state == FULL);
    assign in_tready  = !out_tvalid || out_tready;
    assign accept     = in_tvalid && in_tready;

    // The first beat of a frame uses the live len because len_q is only latched on that beat.
    assign frame_len = (cnt == '0) ? len : len_q;
    assign dump      = accept && ((cnt == frame_len) || in_tlast);

    assign beat_i  = {{(ACC_WIDTH-DATA_WIDTH){in_tdata[2*DATA_WIDTH-1]}},
                      in_tdata[2*DATA_WIDTH-1:DATA_WIDTH]};
    assign beat_q  = {{(ACC_WIDTH-DATA_WIDTH){in_tdata[DATA_WIDTH-1]}},
                      in_tdata[DATA_WIDTH-1:0]};
    assign total_i = acc_i + beat_i;
    assign total_q = acc_q + beat_q;

    assign scaled_i = (total_i + ROUND_BIAS) >>> SHIFT;
    assign scaled_q = (total_q + ROUND_BIAS) >>> SHIFT;

    assign {clip_i, sat_i} = saturate(scaled_i);
    assign {clip_q, sat_q} = saturate(scaled_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ACCUM;
            acc_i     <= '0;
            acc_q     <= '0;
            cnt       <= '0;
            len_q     <= '0;
            out_tdata <= '0;
            out_tlast <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            if (accept) begin
                if (cnt == '0)
                    len_q <= len;
                if (dump) begin
                    acc_i <= '0;
                    acc_q <= '0;
                    cnt   <= '0;
                end else begin
                    acc_i <= total_i;
                    acc_q <= total_q;
                    cnt   <= cnt + LEN_WIDTH'(1);
                end
            end
            // A new dump overrides a simultaneous drain so out_tvalid stays high.
            if (dump) begin
                state     <= FULL;
                out_tdata <= {sat_i, sat_q};
                out_tlast <= in_tlast;
                out_sat   <= clip_i || clip_q;
            end else if (out_tready) begin
                state <= ACCUM;
            end
        end
    end

endmodule

// File: tb/tb_iq_integrate_dump.sv
// Randomized self-checking bench for iq_integrate_dump against an arithmetic frame model.
// Honors IQ_INTDUMP_ROUND_EN in its expected values.
module tb_iq_integrate_dump;

    localparam int DW    = 16;
    localparam int OW    = 16;
    localparam int LW    = 8;
    localparam int AW    = 32;
    localparam int SHIFT = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [LW-1:0]   len;
    logic            in_tvalid;
    logic            in_tready;
    logic [2*DW-1:0] in_tdata;
    logic            in_tlast;
    logic            out_tvalid;
    logic            out_tready;
    logic [2*OW-1:0] out_tdata;
    logic            out_tlast;
    logic            out_sat;

    int checks   = 0;
    int failures = 0;

    longint    m_ai, m_aq;
    int        m_cnt, m_len;
    bit        m_valid;
    bit        m_last, m_sat;
    bit [31:0] m_data;

    iq_integrate_dump #(
        .DATA_WIDTH(DW), .OUT_WIDTH(OW), .LEN_WIDTH(LW), .ACC_WIDTH(AW), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .reset(reset), .len(len),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata), .in_tlast(in_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
        .out_tlast(out_tlast), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Floor (or round-half-up) division by 2^SHIFT, then clamp to the output range.
    function automatic longint scaleSum(input longint t, output bit clipped);
        longint d = longint'(1) << SHIFT;
        longint r;
`ifdef IQ_INTDUMP_ROUND_EN
        t = t + d / 2;
`endif
        if (t >= 0) r = t / d;
        else        r = -((-t + d - 1) / d);
        clipped = 1'b0;
        if (r > 32767)  begin r = 32767;  clipped = 1'b1; end
        if (r < -32768) begin r = -32768; clipped = 1'b1; end
        return r;
    endfunction

    task automatic modelReset();
        m_ai = 0; m_aq = 0; m_cnt = 0; m_len = 0;
        m_valid = 1'b0; m_last = 1'b0; m_sat = 1'b0; m_data = '0;
    endtask

    // One cycle: drive inputs, check against the model, advance the model, step the clock.
    task automatic applyStimulus(input bit valid, input logic signed [15:0] i,
                                 input logic signed [15:0] q, input bit last,
                                 input int l, input bit ordy);
        bit     exp_ready, ci, cq;
        longint ri, rq;
        in_tvalid  = valid;
        in_tdata   = {i, q};
        in_tlast   = last;
        len        = LW'(l);
        out_tready = ordy;
        #2;
        exp_ready = !m_valid || ordy;
        checkOutput("in_tready", 64'(in_tready), 64'(exp_ready));
        checkOutput("out_tvalid", 64'(out_tvalid), 64'(m_valid));
        if (m_valid) begin
            checkOutput("out_tdata", 64'(out_tdata), 64'(m_data));
            checkOutput("out_tlast", 64'(out_tlast), 64'(m_last));
            checkOutput("out_sat", 64'(out_sat), 64'(m_sat));
        end
        if (m_valid && ordy)
            m_valid = 1'b0;
        if (valid && exp_ready) begin
            if (m_cnt == 0)
                m_len = l;
            m_ai = m_ai + longint'(i);
            m_aq = m_aq + longint'(q);
            if (m_cnt == m_len || last) begin
                ri = scaleSum(m_ai, ci);
                rq = scaleSum(m_aq, cq);
                m_data  = {16'(ri), 16'(rq)};
                m_sat   = ci || cq;
                m_last  = last;
                m_valid = 1'b1;
                m_ai = 0; m_aq = 0; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            applyStimulus(1'b0, 16'sd0, 16'sd0, 1'b0, 0, 1'b1);
    endtask

    initial begin
        reset = 1'b0; len = '0; in_tvalid = 1'b0; in_tdata = '0; in_tlast = 1'b0; out_tready = 1'b1;
        modelReset();
        #3;
        checkOutput("rst_out_tvalid", 64'(out_tvalid), 64'd0);
        checkOutput("rst_in_tready", 64'(in_tready), 64'd1);
        checkOutput("rst_out_tdata", 64'(out_tdata), 64'd0);
        checkOutput("rst_out_tlast", 64'(out_tlast), 64'd0);
        checkOutput("rst_out_sat", 64'(out_sat), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle(1);

        $display("[TB] len=3 frame of four beats");
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, 16'sd100, -16'sd50, 1'b0, 3, 1'b1);
        idle(2);

        $display("[TB] early termination by in_tlast");
        applyStimulus(1'b1, 16'sd10, 16'sd6, 1'b0, 7, 1'b1);
        applyStimulus(1'b1, 16'sd10, 16'sd6, 1'b1, 7, 1'b1);
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, 16'sd8, 16'sd4, 1'b0, 3, 1'b1);
        idle(2);

        $display("[TB] len=0 with output backpressure");
        applyStimulus(1'b1, 16'sd40, 16'sd8, 1'b0, 0, 1'b0);
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, -16'sd20, 16'sd12, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, -16'sd20, 16'sd12, 1'b0, 0, 1'b1);
        idle(2);

        $display("[TB] full-scale 256-beat frame saturates");
        for (int k = 0; k < 256; k++)
            applyStimulus(1'b1, 16'sd32767, -16'sd32768, 1'b0, 255, 1'b1);
        idle(2);

        $display("[TB] scaling and rounding on sums 6 and -6");
        applyStimulus(1'b1, 16'sd3, -16'sd3, 1'b0, 1, 1'b1);
        applyStimulus(1'b1, 16'sd3, -16'sd3, 1'b0, 1, 1'b1);
        idle(2);

        $display("[TB] reset in the middle of a frame");
        applyStimulus(1'b1, 16'sd500, 16'sd500, 1'b0, 3, 1'b1);
        applyStimulus(1'b1, 16'sd500, 16'sd500, 1'b0, 3, 1'b1);
        in_tvalid = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("midrst_out_tvalid", 64'(out_tvalid), 64'd0);
        checkOutput("midrst_out_tdata", 64'(out_tdata), 64'd0);
        checkOutput("midrst_in_tready", 64'(in_tready), 64'd1);
        modelReset();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, 16'sd1, 16'sd1, 1'b0, 3, 1'b1);
        idle(2);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 600; k++)
            applyStimulus(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                          ($urandom_range(0, 9) == 0), int'($urandom_range(0, 5)),
                          ($urandom_range(0, 9) < 7));
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iq_integrate_dump.md
# iq_integrate_dump

Integrate-and-dump stage directly downstream of the complex multiplier: consumes its streamed I/Q product samples, accumulates I and Q independently over a programmable number of beats (or until `in_tlast`), then emits one scaled, saturated I/Q sum per frame. Typical use is correlation against a reference: the multiplier mixes, this block integrates.

## Interface
- `DATA_WIDTH`, 16, signed width of each input I and Q component
- `OUT_WIDTH`, 16, signed width of each output I and Q component
- `LEN_WIDTH`, 8, width of the frame-length port
- `ACC_WIDTH`, 32, accumulator width per component; must be ≥ DATA_WIDTH+LEN_WIDTH
- `SHIFT`, 2, arithmetic right shift applied to the sum before saturation (0..ACC_WIDTH-OUT_WIDTH)

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `len`  in  LEN_WIDTH  frame length minus 1; sampled on the first beat of each frame
- `in_tvalid`  in  1  input beat valid
- `in_tready`  out  1  input beat accepted when both high
- `in_tdata`  in  2*DATA_WIDTH  I in upper half, Q in lower half, two's complement
- `in_tlast`  in  1  forces a dump on this beat
- `out_tvalid`  out  1  result valid
- `out_tready`  in  1  downstream ready
- `out_tdata`  out  2*OUT_WIDTH  I upper, Q lower
- `out_tlast`  out  1  result was terminated by `in_tlast`
- `out_sat`  out  1  I or Q saturated in this result

## Operation
- Beat accepted when `in_tvalid && in_tready`; `in_tready = !out_tvalid || out_tready` (combinational; one-entry output register).
- Per accepted beat: sign-extend I and Q to ACC_WIDTH, add into `acc_i`/`acc_q`; frame counter `cnt` increments.
- On first beat of a frame (`cnt==0`) latch `len` into `len_q`; `len` changes mid-frame are ignored.
- Dump condition on an accepted beat: `cnt==len_q` (use `len` directly when `cnt==0`) or `in_tlast`.
- On dump: total = acc + current beat; result = total >>> SHIFT (see Configuration); saturate each component to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; load `out_tdata`, set `out_sat` if either clipped, `out_tlast = in_tlast`; clear acc and `cnt` to 0 in the same edge.
- `len=0`: every beat dumps (scaled pass-through).
- Accumulator wraps mod 2^ACC_WIDTH; parameter constraint guarantees no wrap for full-scale input.
- Output register holds value and flags stable while `out_tvalid && !out_tready`.
- States: ACCUM (cnt counting, out empty or draining), FULL (out_tvalid high, in_tready follows out_tready). Simultaneous drain and new dump in same cycle: old result leaves, new one loads, out_tvalid stays high.

## Timing
- Reset (async assert, sync release by system): acc, cnt, len_q = 0; `out_tvalid`=0, `out_tdata`=0, `out_tlast`=0, `out_sat`=0; `in_tready`=1.
- Latency: dump beat accepted at edge k → `out_tvalid` high after edge k (visible cycle k+1).
- Throughput: one input beat per cycle while output drains each cycle; dump beats never stall unless output held.
- Reset mid-frame discards partial sum and any pending result.

## Configuration
- `IQ_INTDUMP_ROUND_EN` defined: add 2^(SHIFT-1) to total before the shift (round half up); no add when SHIFT=0.
- Undefined: plain arithmetic shift (floor toward −∞).

## Test plan
- len=3, four beats I=100 Q=-50, out_tready=1 → one output I=100 Q=-50, out_tvalid one cycle after 4th beat, out_sat=0, out_tlast=0.
- len=7, beats I=10 Q=6 with in_tlast on 2nd → I=5 Q=3, out_tlast=1; next beat starts new frame at cnt=0.
- len=0, out_tready=0 after first result → in_tready=0, out_tdata stable; raise out_tready → result drains, next beat accepted same cycle.
- len=255, 256 beats I=32767 Q=-32768 → I=32767 Q=-32768, out_sat=1.
- SHIFT=2, sums I=6 Q=-6 → without macro I=1 Q=-2; with `IQ_INTDUMP_ROUND_EN` I=2 Q=-1.
- len=3, assert reset after 2 beats → all outputs 0 immediately; after release four beats I=1 Q=1 with SHIFT=0 → I=4 Q=4.
